// File: rtl/key_debounce_pkg.sv
// ============================================================================
// key_pkg : shared state encoding and default constants for key_debounce.
// Revision: 1.0
// ============================================================================
`default_nettype none

package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned KEY_TICK_DIV_DEFAULT = 50000;
  localparam int unsigned KEY_STABLE_N_DEFAULT = 20;
  localparam int unsigned KEY_LONG_N_DEFAULT   = 1000;

endpackage

`default_nettype wire

// File: rtl/key_debounce_if.sv
// ============================================================================
// key_debounce_if : raw key input and conditioned key events.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface key_debounce_if;

  logic key_in;
  logic key_level;
  logic press;
  logic release_pulse;
  logic toggle;
  logic long_press;

  modport slave (
    input  key_in,
    output key_level,
    output press,
    output release_pulse,
    output toggle,
    output long_press
  );

  modport master (
    output key_in,
    input  key_level,
    input  press,
    input  release_pulse,
    input  toggle,
    input  long_press
  );

endinterface

`default_nettype wire

// File: rtl/key_debounce_tick_gen.sv
// ============================================================================
// tick_gen : free-running prescaler, one-CLK tick every TICK_DIV cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int unsigned TICK_DIV = key_pkg::KEY_TICK_DIV_DEFAULT
) (
  input  logic CLK,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// key_debounce : synchronizes and debounces one raw key into level, press,
// release, toggle and (with LONG_PRESS_EN defined) long-press events.
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned TICK_DIV   = KEY_TICK_DIV_DEFAULT,
  parameter int unsigned STABLE_N   = KEY_STABLE_N_DEFAULT,
  parameter int unsigned LONG_N     = KEY_LONG_N_DEFAULT,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic           CLK,
  input  logic           rst,
  key_debounce_if.slave  bus
);

  localparam int unsigned   SW          = $clog2(STABLE_N + 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_N);
  localparam logic          RAW_IDLE    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic        tick;
  logic [1:0]  sync_q;
  logic        key_s;

  key_state_e  state_q;
  key_state_e  state_d;
  logic [SW-1:0] stb_q;
  logic [SW-1:0] stb_d;
  logic [SW-1:0] stb_inc;
  logic        press_evt;
  logic        release_evt;

  logic        key_level_q;
  logic        press_q;
  logic        release_q;
  logic        toggle_q;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .rst  (rst),
    .tick (tick)
  );

  // Synchronizer resets to the released raw level so reset exit is silent.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      sync_q <= {2{RAW_IDLE}};
    end else begin
      sync_q <= {sync_q[0], bus.key_in};
    end
  end

  assign key_s   = sync_q[1] ^ RAW_IDLE;
  assign stb_inc = stb_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    stb_d       = stb_q;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        // A drop on a tick cycle aborts rather than counts.
        if (!key_s) begin
          state_d = IDLE;
        end else if (tick) begin
          if (stb_inc == STABLE_LAST) begin
            state_d   = HELD;
            press_evt = 1'b1;
          end else begin
            stb_d = stb_inc;
          end
        end
      end
      HELD: begin
        if (!key_s) begin
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_d = HELD;
        end else if (tick) begin
          if (stb_inc == STABLE_LAST) begin
            state_d     = IDLE;
            release_evt = 1'b1;
          end else begin
            stb_d = stb_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) begin
      stb_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      toggle_q    <= 1'b0;
    end else begin
      press_q   <= press_evt;
      release_q <= release_evt;
      if (press_evt) begin
        key_level_q <= 1'b1;
        toggle_q    <= ~toggle_q;
      end else if (release_evt) begin
        key_level_q <= 1'b0;
      end
    end
  end

  assign bus.key_level     = key_level_q;
  assign bus.press         = press_q;
  assign bus.release_pulse = release_q;
  assign bus.toggle        = toggle_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned   LW        = $clog2(LONG_N + 1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_N);

  logic [LW-1:0] long_cnt_q;
  logic [LW-1:0] long_cnt_d;
  logic [LW-1:0] long_inc;
  logic          long_evt;
  logic          long_q;

  assign long_inc = long_cnt_q + 1'b1;

  // Saturates at LONG_N; RELEASE_WAIT only holds so a bounce back keeps it.
  always_comb begin
    long_cnt_d = long_cnt_q;
    long_evt   = 1'b0;
    case (state_q)
      HELD: begin
        if (tick && (long_cnt_q != LONG_LAST)) begin
          long_cnt_d = long_inc;
          long_evt   = (long_inc == LONG_LAST);
        end
      end
      RELEASE_WAIT: begin
        long_cnt_d = long_cnt_q;
      end
      default: begin
        long_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_evt;
    end
  end

  assign bus.long_press = long_q;
`else
  assign bus.long_press = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ============================================================================
// tb_key_debounce : directed stimulus with a pulse scoreboard for key_debounce.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_key_debounce;

  localparam int KIND_PRESS   = 0;
  localparam int KIND_RELEASE = 1;
  localparam int KIND_LONG    = 2;

  typedef struct {
    int   kind;
    int   lo;
    int   hi;
    logic lvl;
    logic tog;
  } exp_t;

  logic CLK = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  key_debounce_if u_if ();

  key_debounce #(
    .TICK_DIV   (4),
    .STABLE_N   (3),
    .LONG_N     (5),
    .ACTIVE_LOW (1)
  ) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_win(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got cycle %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected event.
  always @(negedge CLK) begin
    logic [2:0] p;
    p = {u_if.long_press, u_if.release_pulse, u_if.press};
    for (int k = 0; k < 3; k++) begin
      if (p[k] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", k, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("pulse_kind", k, mon_e.kind);
          check_win("pulse_time", cyc, mon_e.lo, mon_e.hi);
          check("pulse_key_level", int'(u_if.key_level), int'(mon_e.lvl));
          check("pulse_toggle", int'(u_if.toggle), int'(mon_e.tog));
        end
      end
    end
  end

  task automatic push(input int kind, input int lo, input int hi, input logic lvl, input logic tog);
    exp_t e;
    e.kind = kind;
    e.lo   = lo;
    e.hi   = hi;
    e.lvl  = lvl;
    e.tog  = tog;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
    check("scoreboard_drain", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_idle_outputs(input string tag, input logic tog);
    check({tag, "_key_level"}, int'(u_if.key_level), 0);
    check({tag, "_toggle"}, int'(u_if.toggle), int'(tog));
  endtask

  // Press at edge+12..15 (2 sync + IDLE exit + 3 ticks of period 4); long 20 later.
  task automatic press_hold(input logic tog_after);
    int c0;
    c0 = cyc;
    u_if.key_in = 1'b0;
    push(KIND_PRESS, c0 + 12, c0 + 15, 1'b1, tog_after);
`ifdef LONG_PRESS_EN
    push(KIND_LONG, c0 + 28, c0 + 39, 1'b1, tog_after);
`endif
    repeat (60) @(negedge CLK);
    check("held_key_level", int'(u_if.key_level), 1);
    check("held_toggle", int'(u_if.toggle), int'(tog_after));
    wait_drain();
  endtask

  task automatic release_key(input logic tog);
    int c0;
    c0 = cyc;
    u_if.key_in = 1'b1;
    push(KIND_RELEASE, c0 + 12, c0 + 15, 1'b0, tog);
    repeat (40) @(negedge CLK);
    check_idle_outputs("released", tog);
    wait_drain();
  endtask

  initial begin
    rst = 1'b1;
    u_if.key_in = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_key_level", int'(u_if.key_level), 0);
    check("rst_press", int'(u_if.press), 0);
    check("rst_release", int'(u_if.release_pulse), 0);
    check("rst_toggle", int'(u_if.toggle), 0);
    check("rst_long", int'(u_if.long_press), 0);
    rst = 1'b1;
    repeat (50) @(negedge CLK);
    check_idle_outputs("post_reset", 1'b0);

    for (int i = 0; i < 20; i++) begin
      u_if.key_in = ~u_if.key_in;
      repeat (3) @(negedge CLK);
    end
    u_if.key_in = 1'b1;
    repeat (30) @(negedge CLK);
    check_idle_outputs("bounce", 1'b0);

    press_hold(1'b1);
    release_key(1'b1);
    press_hold(1'b0);
    release_key(1'b0);

    // Third press aborted by reset while still in PRESS_WAIT.
    u_if.key_in = 1'b0;
    repeat (6) @(negedge CLK);
    rst = 1'b0;
    u_if.key_in = 1'b1;
    repeat (3) @(negedge CLK);
    check_idle_outputs("mid_reset", 1'b0);
    rst = 1'b1;
    repeat (30) @(negedge CLK);
    check_idle_outputs("after_abort", 1'b0);
    check("final_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
